// File: rtl/btn_conditioner.sv
// btn_conditioner
//   Player-input front end: synchronizes and debounces four raw buttons, then
//   accepts a single press at a time and reports it as a 2-bit button number
//   with a held flag and one-cycle press/release strobes. Presses of two or
//   more buttons are refused until every button has been released.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high
//   btns[3:0]     raw asynchronous buttons, active-high
//   enable        allows new presses to be accepted (does not abort a held one)
//   num[1:0]      index of the accepted button; holds after release
//   pressed       high while the accepted button stays stably held
//   press_pulse   one-cycle strobe on acceptance
//   release_pulse one-cycle strobe on release of the accepted button

// One button lane: two-flop synchronizer followed by a counting debouncer.
// The stable level only flips after DEBOUNCE_CYCLES consecutive disagreeing
// samples; any agreeing sample restarts the count.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1, s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btns,
    input  logic       enable,
    output logic [1:0] num,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse
);
    localparam int NUM_BTNS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    logic [NUM_BTNS-1:0] stable;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_lane
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (btns[g]),
            .stable(stable[g])
        );
    end

    state_t     state, state_n;
    logic [1:0] num_n;
    logic       pressed_n, press_pulse_n, release_pulse_n;
    logic       one_hot, multi;
    logic [1:0] enc;

    // x & (x-1) clears the lowest set bit: non-zero means two or more set.
    assign multi   = (stable & (stable - 4'd1)) != 4'd0;
    assign one_hot = (stable != 4'd0) && !multi;

    always_comb begin
        enc = 2'd0;
        case (stable)
            4'b0010: enc = 2'd1;
            4'b0100: enc = 2'd2;
            4'b1000: enc = 2'd3;
            default: enc = 2'd0;
        endcase
    end

    always_comb begin
        state_n         = state;
        num_n           = num;
        pressed_n       = pressed;
        press_pulse_n   = 1'b0;
        release_pulse_n = 1'b0;
        case (state)
            IDLE: begin
                if (multi) begin
                    state_n = LOCKOUT;
                end else if (enable && one_hot) begin
                    state_n       = HELD;
                    num_n         = enc;
                    pressed_n     = 1'b1;
                    press_pulse_n = 1'b1;
                end
            end
            HELD: begin
                // Only the accepted button matters; others are ignored until
                // it lets go, then decide whether anything is still down.
                if (!stable[num]) begin
                    pressed_n       = 1'b0;
                    release_pulse_n = 1'b1;
                    state_n         = (stable == 4'd0) ? IDLE : LOCKOUT;
                end
            end
            LOCKOUT: begin
                pressed_n = 1'b0;
                if (stable == 4'd0) state_n = IDLE;
            end
            default: begin
                state_n   = IDLE;
                pressed_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            num           <= 2'd0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            num           <= num_n;
            pressed       <= pressed_n;
            press_pulse   <= press_pulse_n;
            release_pulse <= release_pulse_n;
        end
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner with a short debounce window. A behavioural
// model tracks the raw sample history and the accepted-press rules; every
// cycle the DUT outputs are compared against it, and directed steps add
// latency and strobe-count checks.
module tb_btn_conditioner;
    localparam int D     = 4;
    localparam int CNT_W = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btns;
    logic       enable;
    logic [1:0] num;
    logic       pressed, press_pulse, release_pulse;

    btn_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .btns         (btns),
        .enable       (enable),
        .num          (num),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc_n  = 0;
    int npress = 0, nrel = 0;
    int press_at = -1, rel_at = -1;

    // Reference model. hist[0] is the newest raw sample; the synchronized
    // input seen by an edge is two samples old, so a stable bit flips when
    // the D samples hist[1..D] all disagree with it.
    logic [3:0] hist [D+1];
    logic [3:0] m_stable = 4'd0;
    int         m_held   = -1;
    bit         m_lock   = 1'b0;
    logic [1:0] m_num    = 2'd0;
    logic       m_pressed = 1'b0, m_pp = 1'b0, m_rp = 1'b0;

    task automatic model_step(input logic [3:0] b, input logic en, input logic rst);
        bit flip;
        if (rst) begin
            for (int k = 0; k <= D; k++) hist[k] = 4'd0;
            m_stable = 4'd0; m_held = -1; m_lock = 1'b0;
            m_num = 2'd0; m_pressed = 1'b0; m_pp = 1'b0; m_rp = 1'b0;
            return;
        end
        m_pp = 1'b0;
        m_rp = 1'b0;
        if (m_held >= 0) begin
            if (!m_stable[m_held]) begin
                m_pressed = 1'b0; m_rp = 1'b1;
                m_lock = (m_stable != 4'd0);
                m_held = -1;
            end
        end else if (m_lock) begin
            if (m_stable == 4'd0) m_lock = 1'b0;
        end else if ($countones(m_stable) >= 2) begin
            m_lock = 1'b1;
        end else if (en && $countones(m_stable) == 1) begin
            for (int i = 0; i < 4; i++) if (m_stable[i]) m_held = i;
            m_num = 2'(m_held); m_pressed = 1'b1; m_pp = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            flip = 1'b1;
            for (int k = 1; k <= D; k++) if (hist[k][i] == m_stable[i]) flip = 1'b0;
            if (flip) m_stable[i] = ~m_stable[i];
        end
        for (int k = D; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = b;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // One clock: drive, advance model with the DUT edge, compare at negedge.
    task automatic cyc(input logic [3:0] b, input logic en, input logic rst);
        btns = b; enable = en; reset = rst;
        @(posedge clk);
        model_step(b, en, rst);
        cyc_n++;
        @(negedge clk);
        chk("num", 32'(num), 32'(m_num));
        chk("pressed", 32'(pressed), 32'(m_pressed));
        chk("press_pulse", 32'(press_pulse), 32'(m_pp));
        chk("release_pulse", 32'(release_pulse), 32'(m_rp));
        chk("pulse_overlap", 32'(press_pulse & release_pulse), 32'd0);
        if (press_pulse === 1'b1)   begin npress++; press_at = cyc_n; end
        if (release_pulse === 1'b1) begin nrel++;   rel_at   = cyc_n; end
    endtask

    task automatic hold(input logic [3:0] b, input logic en, input int n);
        repeat (n) cyc(b, en, 1'b0);
    endtask

    initial begin
        int c0, np0, nr0, len, sel;
        logic [3:0] pat;
        logic       en;
        for (int k = 0; k <= D; k++) hist[k] = 4'd0;

        // Reset with all buttons down, then the cycle after release of reset.
        repeat (3) cyc(4'b1111, 1'b0, 1'b1);
        chk("rst_num", 32'(num), 32'd0);
        chk("rst_pressed", 32'(pressed), 32'd0);
        cyc(4'b1111, 1'b0, 1'b0);
        chk("rst_after_pp", 32'(press_pulse), 32'd0);
        hold(4'b0000, 1'b1, 10);

        // Clean press and release of button 2.
        np0 = npress; nr0 = nrel;
        c0 = cyc_n; cyc(4'b0100, 1'b1, 1'b0);
        hold(4'b0100, 1'b1, 19);
        chk("clean_press_lat", 32'(press_at - c0), 32'(D + 3));
        chk("clean_press_cnt", 32'(npress - np0), 32'd1);
        chk("clean_num", 32'(num), 32'd2);
        c0 = cyc_n; cyc(4'b0000, 1'b1, 1'b0);
        hold(4'b0000, 1'b1, 9);
        chk("clean_rel_lat", 32'(rel_at - c0), 32'(D + 3));
        chk("clean_rel_cnt", 32'(nrel - nr0), 32'd1);
        chk("clean_num_hold", 32'(num), 32'd2);

        // Bouncing button 0 never settles long enough, then a steady hold.
        np0 = npress;
        repeat (5) begin
            hold(4'b0001, 1'b1, 3);
            hold(4'b0000, 1'b1, 1);
        end
        chk("bounce_none", 32'(npress - np0), 32'd0);
        c0 = cyc_n; cyc(4'b0001, 1'b1, 1'b0);
        hold(4'b0001, 1'b1, 11);
        chk("bounce_lat", 32'(press_at - c0), 32'(D + 3));
        chk("bounce_num", 32'(num), 32'd0);
        hold(4'b0000, 1'b1, 10);

        // Two buttons at once lock out until everything is released.
        np0 = npress;
        hold(4'b0011, 1'b1, 10);
        chk("multi_none", 32'(npress - np0), 32'd0);
        hold(4'b0001, 1'b1, 10);
        chk("multi_drop_none", 32'(npress - np0), 32'd0);
        hold(4'b0000, 1'b1, 10);
        hold(4'b1000, 1'b1, 10);
        chk("multi_then_press", 32'(npress - np0), 32'd1);
        chk("multi_num", 32'(num), 32'd3);
        hold(4'b0000, 1'b1, 10);

        // Enable gating: held while disabled, accepted as enable rises.
        np0 = npress; nr0 = nrel;
        hold(4'b0010, 1'b0, 10);
        chk("en_none", 32'(npress - np0), 32'd0);
        c0 = cyc_n; cyc(4'b0010, 1'b1, 1'b0);
        hold(4'b0010, 1'b1, 3);
        chk("en_lat", 32'(press_at - c0), 32'd1);
        chk("en_num", 32'(num), 32'd1);
        hold(4'b0000, 1'b0, 10);
        chk("en_rel_cnt", 32'(nrel - nr0), 32'd1);

        // Reset while holding button 3: no release, re-accepted afterwards.
        hold(4'b1000, 1'b1, 10);
        chk("mid_held", 32'(pressed), 32'd1);
        nr0 = nrel;
        c0 = cyc_n; cyc(4'b1000, 1'b1, 1'b1);
        chk("mid_rst_pressed", 32'(pressed), 32'd0);
        hold(4'b1000, 1'b1, 10);
        chk("mid_rst_lat", 32'(press_at - c0), 32'(D + 4));
        chk("mid_rst_norel", 32'(nrel - nr0), 32'd0);
        hold(4'b0000, 1'b1, 10);

        // Randomized segments against the model.
        for (int s = 0; s < 60; s++) begin
            sel = $urandom_range(0, 9);
            len = $urandom_range(1, 12);
            en  = ($urandom_range(0, 4) != 0);
            if (sel <= 4)      pat = 4'(1 << $urandom_range(0, 3));
            else if (sel == 7) pat = 4'($urandom_range(0, 15));
            else               pat = 4'd0;
            for (int k = 0; k < len; k++) begin
                if (sel == 8) pat = 4'($urandom_range(0, 15));
                cyc(pat, en, ($urandom_range(0, 60) == 0));
            end
        end
        hold(4'b0000, 1'b1, 10);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
